// File: rtl/xlr8_tone_pkg.sv
// Shared types and default parameters for the XLR8 speaker tone sequencer.
package xlr8_tone_pkg;

  localparam int DIV_W_DEF      = 16;
  localparam int DUR_W_DEF      = 12;
  localparam int TICK_DIV_DEF   = 16000;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP
  } tone_state_t;

  typedef struct packed {
    logic [DIV_W_DEF-1:0] period;
    logic [DUR_W_DEF-1:0] dur;
    logic [1:0]           ch;
  } note_t;

endpackage

// File: rtl/xlr8_tone_fifo.sv
// Synchronous note queue; pointers carry one extra bit so full and empty differ.
module xlr8_tone_fifo
  import xlr8_tone_pkg::*;
#(
  parameter int  DEPTH = FIFO_DEPTH_DEF,
  parameter type T     = note_t
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  T                       din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output T                       head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  T            mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/xlr8_tone_gen.sv
// Speaker tone sequencer: plays queued notes back-to-back as square waves on two pins,
// with a one-tick silent gap after each note.
module xlr8_tone_gen
  import xlr8_tone_pkg::*;
#(
  parameter int DIV_W      = DIV_W_DEF,
  parameter int DUR_W      = DUR_W_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             note_wr,
  input  logic [DIV_W-1:0] note_period,
  input  logic [DUR_W-1:0] note_dur,
  input  logic [1:0]       note_ch,
  output logic             fifo_full,
  output logic             busy,
  output logic             ovf,
  output logic             note_done,
  output logic             spk1_out,
  output logic             spk2_out
);

  localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PS_W-1:0] TICK_LAST = PS_W'(TICK_DIV - 1);

  typedef struct packed {
    logic [DIV_W-1:0] period;
    logic [DUR_W-1:0] dur;
    logic [1:0]       ch;
  } slot_t;

  tone_state_t      state_q, state_d;
  logic [DIV_W-1:0] period_q, period_d, div_cnt_q, div_cnt_d;
  logic [DUR_W-1:0] dur_q, dur_d, tick_q, tick_d;
  logic [1:0]       ch_q, ch_d;
  logic [PS_W-1:0]  presc_q, presc_d;
  logic             phase_q, phase_d, ovf_q, ovf_d, done_q, done_d;
  logic             spk1_q, spk1_d, spk2_q, spk2_d;

  logic             push, pop, flush, fifo_empty, tick_wrap;
  logic [LVL_W-1:0] fifo_level;
  slot_t            wr_slot, head;

  assign wr_slot = '{period: note_period, dur: note_dur, ch: note_ch};
  // Full is sampled before any same-cycle pop, so a write into a full queue is always dropped.
  assign push    = note_wr && enable && !fifo_full;

  xlr8_tone_fifo #(.DEPTH(FIFO_DEPTH), .T(slot_t)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (wr_slot),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level),
    .head  (head)
  );

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    dur_d     = dur_q;
    ch_d      = ch_q;
    div_cnt_d = div_cnt_q;
    presc_d   = presc_q;
    tick_d    = tick_q;
    phase_d   = phase_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    tick_wrap = (presc_q == TICK_LAST);

    if (!enable) begin
      state_d   = IDLE;
      flush     = 1'b1;
      ovf_d     = 1'b0;
      phase_d   = 1'b0;
      div_cnt_d = '0;
      presc_d   = '0;
      tick_d    = '0;
    end else begin
      if (note_wr && fifo_full) ovf_d = 1'b1;
      unique case (state_q)
        IDLE: if (!fifo_empty) state_d = LOAD;
        LOAD: begin
          pop       = 1'b1;
          period_d  = head.period;
          dur_d     = head.dur;
          ch_d      = head.ch;
          div_cnt_d = '0;
          presc_d   = '0;
          tick_d    = '0;
          phase_d   = 1'b0;
          // A zero-length note is skipped; look past the entry being popped right now.
          if (head.dur == '0) begin
            state_d = (fifo_level > LVL_W'(1) || push) ? LOAD : IDLE;
          end else begin
            state_d = PLAY;
          end
        end
        PLAY: begin
          if (period_q != '0) begin
            if (div_cnt_q == period_q - DIV_W'(1)) begin
              div_cnt_d = '0;
              phase_d   = !phase_q;
            end else begin
              div_cnt_d = div_cnt_q + DIV_W'(1);
            end
          end
          if (tick_wrap) begin
            presc_d = '0;
            tick_d  = tick_q + DUR_W'(1);
            if (tick_q == dur_q - DUR_W'(1)) begin
              done_d    = 1'b1;
              phase_d   = 1'b0;
              div_cnt_d = '0;
              tick_d    = '0;
              state_d   = GAP;
            end
          end else begin
            presc_d = presc_q + PS_W'(1);
          end
        end
        GAP: begin
          if (tick_wrap) begin
            presc_d = '0;
            state_d = fifo_empty ? IDLE : LOAD;
          end else begin
            presc_d = presc_q + PS_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs follow the next-state values so a pin rises exactly `period` cycles into PLAY.
    spk1_d = phase_d && ch_d[0] && (state_d == PLAY) && (period_d != '0);
    spk2_d = phase_d && ch_d[1] && (state_d == PLAY) && (period_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      period_q  <= '0;
      dur_q     <= '0;
      ch_q      <= '0;
      div_cnt_q <= '0;
      presc_q   <= '0;
      tick_q    <= '0;
      phase_q   <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      spk1_q    <= 1'b0;
      spk2_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      dur_q     <= dur_d;
      ch_q      <= ch_d;
      div_cnt_q <= div_cnt_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      phase_q   <= phase_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      spk1_q    <= spk1_d;
      spk2_q    <= spk2_d;
    end
  end

  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign ovf       = ovf_q;
  assign note_done = done_q;
  assign spk1_out  = spk1_q;
  assign spk2_out  = spk2_q;

endmodule

// File: tb/tb_xlr8_tone_gen.sv
// Directed bench for xlr8_tone_gen with a 10-cycle tick; waveforms are captured per cycle
// and compared against hand-derived bit masks.
module tb_xlr8_tone_gen;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        note_wr = 1'b0;
  logic [15:0] note_period = '0;
  logic [11:0] note_dur = '0;
  logic [1:0]  note_ch = '0;
  logic        fifo_full, busy, ovf, note_done, spk1_out, spk2_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] cap_s1, cap_s2, cap_nd, cap_busy;

  always #5 clk = ~clk;

  xlr8_tone_gen #(
    .DIV_W(16), .DUR_W(12), .TICK_DIV(10), .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .note_wr     (note_wr),
    .note_period (note_period),
    .note_dur    (note_dur),
    .note_ch     (note_ch),
    .fifo_full   (fifo_full),
    .busy        (busy),
    .ovf         (ovf),
    .note_done   (note_done),
    .spk1_out    (spk1_out),
    .spk2_out    (spk2_out)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] span(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Called at a negedge; the write is taken at the next posedge (cycle 0 of that note).
  task automatic push_note(input logic [15:0] p, input logic [11:0] d, input logic [1:0] c);
    note_period = p;
    note_dur    = d;
    note_ch     = c;
    note_wr     = 1'b1;
    $display("push period=%0d dur=%0d ch=%b", p, d, c);
    @(negedge clk);
    note_wr = 1'b0;
  endtask

  // Bit i holds the output seen at negedge i (i.e. during cycle i).
  task automatic capture(input int lo, input int hi);
    cap_s1   = '0;
    cap_s2   = '0;
    cap_nd   = '0;
    cap_busy = '0;
    for (int i = lo; i <= hi; i++) begin
      cap_s1[i]   = spk1_out;
      cap_s2[i]   = spk2_out;
      cap_nd[i]   = note_done;
      cap_busy[i] = busy;
      @(negedge clk);
    end
  endtask

  initial begin
    rstn   = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", {122'd0, fifo_full, busy, ovf, note_done, spk1_out, spk2_out}, '0);
    rstn   = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    check_eq("idle_busy", {127'd0, busy}, '0);

    // Single note period=3 dur=2 on spk1
    $display("test single note");
    push_note(16'd3, 12'd2, 2'b01);
    capture(1, 40);
    check_eq("single_spk1", cap_s1, span(6, 8) | span(12, 14) | span(18, 20));
    check_eq("single_spk2", cap_s2, '0);
    check_eq("single_done", cap_nd, span(23, 23));
    check_eq("single_busy", cap_busy, span(1, 32));

    // Reset in the middle of a note
    $display("test reset mid-PLAY");
    push_note(16'd3, 12'd5, 2'b11);
    repeat (6) @(negedge clk);
    check_eq("prerst_spk", {126'd0, spk1_out, spk2_out}, 128'd3);
    rstn = 1'b0;
    @(negedge clk);
    check_eq("midrst_outputs", {122'd0, fifo_full, busy, ovf, note_done, spk1_out, spk2_out}, '0);
    @(negedge clk);
    rstn = 1'b1;
    capture(9, 30);
    check_eq("postrst_spk", cap_s1 | cap_s2, '0);
    check_eq("postrst_busy", cap_busy | cap_nd, '0);

    // Hold the sequencer with a silent note, then overfill the queue
    $display("test queue overflow");
    push_note(16'd5, 12'd2, 2'b00);
    push_note(16'd1, 12'd1, 2'b01);
    push_note(16'd1, 12'd1, 2'b10);
    push_note(16'd2, 12'd1, 2'b01);
    push_note(16'd2, 12'd1, 2'b10);
    check_eq("q_full_noovf", {126'd0, fifo_full, ovf}, 128'd2);
    push_note(16'd1, 12'd1, 2'b11);
    check_eq("q_full_ovf", {126'd0, fifo_full, ovf}, 128'd3);
    capture(6, 120);
    check_eq("q_spk1", cap_s1, span(35, 35) | span(37, 37) | span(39, 39) | span(41, 41) |
             span(43, 43) | span(78, 79) | span(82, 83));
    check_eq("q_spk2", cap_s2, span(56, 56) | span(58, 58) | span(60, 60) | span(62, 62) |
             span(64, 64) | span(99, 100) | span(103, 104));
    check_eq("q_done", cap_nd, span(23, 23) | span(44, 44) | span(65, 65) | span(86, 86) |
             span(107, 107));
    check_eq("q_busy", cap_busy, span(6, 116));
    check_eq("q_ovf_sticky", {127'd0, ovf}, 128'd1);
    enable = 1'b0;
    @(negedge clk);
    check_eq("q_ovf_clear", {127'd0, ovf}, '0);
    enable = 1'b1;
    @(negedge clk);

    // Rest then a short spk2 note
    $display("test rest");
    push_note(16'd0, 12'd3, 2'b11);
    push_note(16'd2, 12'd1, 2'b10);
    capture(2, 70);
    check_eq("rest_spk1", cap_s1, '0);
    check_eq("rest_spk2", cap_s2, span(46, 47) | span(50, 51));
    check_eq("rest_done", cap_nd, span(33, 33) | span(54, 54));
    check_eq("rest_busy", cap_busy, span(2, 63));

    // Zero-duration note between two real notes
    $display("test dur=0 skip");
    push_note(16'd1, 12'd1, 2'b01);
    push_note(16'd3, 12'd0, 2'b11);
    push_note(16'd1, 12'd1, 2'b10);
    capture(3, 50);
    check_eq("skip_spk1", cap_s1, span(4, 4) | span(6, 6) | span(8, 8) | span(10, 10) | span(12, 12));
    check_eq("skip_spk2", cap_s2, span(26, 26) | span(28, 28) | span(30, 30) | span(32, 32) |
             span(34, 34));
    check_eq("skip_done", cap_nd, span(13, 13) | span(35, 35));
    check_eq("skip_busy", cap_busy, span(3, 44));

    // Drop enable mid-PLAY with two notes still queued
    $display("test enable drop");
    push_note(16'd4, 12'd5, 2'b11);
    push_note(16'd4, 12'd1, 2'b01);
    push_note(16'd4, 12'd1, 2'b10);
    repeat (7) @(negedge clk);
    check_eq("en_playing", {126'd0, spk1_out, busy}, 128'd3);
    enable = 1'b0;
    @(negedge clk);
    check_eq("en_low_outputs", {122'd0, fifo_full, busy, ovf, note_done, spk1_out, spk2_out}, '0);
    enable = 1'b1;
    capture(11, 40);
    check_eq("en_reen_spk", cap_s1 | cap_s2, '0);
    check_eq("en_reen_busy", cap_busy | cap_nd, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
